// File: rtl/mux_scan_serializer_if.sv
// rtl/mux_scan_serializer_if.sv - parallel-in / serial-out handshake bundle for the mux scan serializer
interface mux_scan_serializer_if #(
   parameter int WIDTH = 4,
   parameter int SEL_W = 2
);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic [SEL_W-1:0] sel;
   logic             ser_out;
   logic             ser_valid;
   logic             ser_ready;
   logic             ser_last;
   logic             busy;

   modport master (
      output in_data, in_valid, ser_ready,
      input  in_ready, sel, ser_out, ser_valid, ser_last, busy
   );

   modport slave (
      input  in_data, in_valid, ser_ready,
      output in_ready, sel, ser_out, ser_valid, ser_last, busy
   );
endinterface

// File: rtl/mux_scan_serializer.sv
// rtl/mux_scan_serializer.sv - steps an external mux select over a captured word, emitting one bit per accepted beat
module mux_scan_serializer #(
   parameter int WIDTH = 4,
   parameter int SEL_W = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   mux_scan_serializer_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} state_t;

   localparam logic [SEL_W-1:0] LAST = SEL_W'(WIDTH - 1);

   state_t           state, state_next;
   logic [WIDTH-1:0] word, word_next;
   logic [SEL_W-1:0] count, count_next;
   logic             in_ready_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         word       <= '0;
         count      <= '0;
         in_ready_q <= 1'b0;
      end else begin
         state      <= state_next;
         word       <= word_next;
         count      <= count_next;
         // Registered ready: high exactly in the cycles spent in IDLE after the first post-reset edge.
         in_ready_q <= (state_next == IDLE);
      end
   end

   always_comb begin
      state_next = state;
      word_next  = word;
      count_next = count;
      case (state)
         IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               word_next  = bus.in_data;
               count_next = '0;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (bus.ser_ready) begin
               if (count == LAST) begin
                  count_next = '0;
                  state_next = DRAIN;
               end else begin
                  count_next = count + SEL_W'(1);
               end
            end
         end
         DRAIN: begin
            count_next = '0;
            state_next = IDLE;
         end
         default: begin
            count_next = '0;
            state_next = IDLE;
         end
      endcase
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.ser_valid = (state == SHIFT);
   assign bus.busy      = (state == SHIFT);
   assign bus.sel       = (state == SHIFT) ? count : '0;
   assign bus.ser_last  = (state == SHIFT) && (count == LAST);
   assign bus.ser_out   = word[bus.sel];
endmodule

// File: tb/tb_mux_scan_serializer.sv
// tb/tb_mux_scan_serializer.sv - directed scoreboard bench for mux_scan_serializer
module tb_mux_scan_serializer;
   localparam int WIDTH = 4;
   localparam int SEL_W = 2;

   typedef struct {
      logic bit_val;
      logic last;
      int   idx;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   vectors = 0;
   int   errors = 0;
   int   cyc = 0;
   int   accept_cyc = 0;
   int   prev_accept_cyc = 0;
   logic accepted;
   exp_t sb[$];

   mux_scan_serializer_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

   mux_scan_serializer #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: score the beat about to be taken, record any acceptance, then advance to edge+1.
   task automatic cycle();
      exp_t e;
      logic take;
      logic acc;
      logic [WIDTH-1:0] d;
      take = bus.ser_valid && bus.ser_ready;
      acc  = bus.in_valid && bus.in_ready;
      d    = bus.in_data;
      if (!bus.ser_valid) chk("sel_zero_when_idle", 32'(bus.sel), 0);
      if (take) begin
         if (sb.size() == 0) begin
            chk("unexpected_bit", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("ser_out", 32'(bus.ser_out), 32'(e.bit_val));
            chk("sel", 32'(bus.sel), 32'(e.idx));
            chk("ser_last", 32'(bus.ser_last), 32'(e.last));
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      accepted = acc;
      if (acc) begin
         prev_accept_cyc = accept_cyc;
         accept_cyc = cyc;
         for (int i = 0; i < WIDTH; i++) begin
            e.bit_val = d[i];
            e.last    = (i == WIDTH - 1);
            e.idx     = i;
            sb.push_back(e);
         end
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   logic [WIDTH-1:0] words [3];
   int idx;
   int budget;

   initial begin
      rst_n        = 1'b0;
      bus.in_data  = '0;
      bus.in_valid = 1'b0;
      bus.ser_ready = 1'b0;

      // Reset then idle
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 0);
      chk("rst_ser_valid", 32'(bus.ser_valid), 0);
      chk("rst_sel", 32'(bus.sel), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_ser_last", 32'(bus.ser_last), 0);
      rst_n = 1'b1;
      #1;
      chk("in_ready_before_edge", 32'(bus.in_ready), 0);
      cycle();
      chk("in_ready_after_release", 32'(bus.in_ready), 1);
      chk("idle_ser_valid", 32'(bus.ser_valid), 0);

      // Basic serialization
      bus.ser_ready = 1'b1;
      bus.in_data   = 4'b1010;
      bus.in_valid  = 1'b1;
      cycle();
      chk("basic_accepted", 32'(accepted), 1);
      bus.in_valid = 1'b0;
      chk("basic_latency_valid", 32'(bus.ser_valid), 1);
      chk("basic_in_ready_low", 32'(bus.in_ready), 0);
      for (int i = 0; i < WIDTH; i++) begin
         chk("basic_valid", 32'(bus.ser_valid), 1);
         chk("basic_busy", 32'(bus.busy), 1);
         cycle();
      end
      chk("drain_valid", 32'(bus.ser_valid), 0);
      chk("drain_busy", 32'(bus.busy), 0);
      chk("drain_in_ready", 32'(bus.in_ready), 0);
      cycle();
      chk("basic_in_ready_back", 32'(bus.in_ready), 1);
      chk("basic_sb_empty", 32'(sb.size()), 0);

      // Backpressure
      bus.ser_ready = 1'b0;
      bus.in_data   = 4'b0110;
      bus.in_valid  = 1'b1;
      cycle();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 32'(bus.ser_valid), 1);
         chk("bp_out", 32'(bus.ser_out), 0);
         chk("bp_sel", 32'(bus.sel), 0);
         cycle();
      end
      bus.ser_ready = 1'b1;
      run(WIDTH + 2);
      chk("bp_sb_empty", 32'(sb.size()), 0);
      chk("bp_in_ready", 32'(bus.in_ready), 1);

      // Input ignored while busy
      bus.in_data  = 4'b1100;
      bus.in_valid = 1'b1;
      cycle();
      bus.in_data = 4'b0011;
      budget = 0;
      accepted = 1'b0;
      while (!accepted && budget < 20) begin
         cycle();
         budget++;
      end
      chk("ign_second_accept", 32'(accepted), 1);
      chk("ign_spacing", 32'(accept_cyc - prev_accept_cyc), WIDTH + 2);
      bus.in_valid = 1'b0;
      run(WIDTH + 2);
      chk("ign_sb_empty", 32'(sb.size()), 0);

      // Async reset mid-word
      bus.in_data  = 4'b1111;
      bus.in_valid = 1'b1;
      cycle();
      bus.in_valid = 1'b0;
      run(2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(bus.ser_valid), 0);
      chk("arst_sel", 32'(bus.sel), 0);
      chk("arst_busy", 32'(bus.busy), 0);
      chk("arst_in_ready", 32'(bus.in_ready), 0);
      sb.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cycle();
      chk("arst_in_ready_back", 32'(bus.in_ready), 1);
      run(6);
      chk("arst_no_residual", 32'(sb.size()), 0);

      // Back-to-back throughput
      words[0] = 4'b0001;
      words[1] = 4'b1000;
      words[2] = 4'b0101;
      idx = 0;
      bus.in_data  = words[0];
      bus.in_valid = 1'b1;
      budget = 0;
      while ((idx < 3 || sb.size() != 0) && budget < 60) begin
         cycle();
         budget++;
         if (accepted) begin
            if (idx > 0) chk("b2b_spacing", 32'(accept_cyc - prev_accept_cyc), WIDTH + 2);
            idx++;
            if (idx == 3) bus.in_valid = 1'b0;
            else bus.in_data = words[idx];
         end
      end
      chk("b2b_words", 32'(idx), 3);
      chk("b2b_sb_empty", 32'(sb.size()), 0);
      run(3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/mux_scan_serializer.md
Name: mux_scan_serializer

Overview:
Parallel-to-serial scanner that feeds the team's 4:1 select-mux datapath. It accepts a WIDTH-bit word over a valid/ready handshake and steps a select index from 0 to WIDTH-1. The index is exported so it can drive an external mux's select input. The bit selected at each step is emitted as a serial stream with its own valid/ready handshake, so downstream stages can apply backpressure.

Parameters:
WIDTH, 4, number of bits per parallel word (number of mux inputs); must be >= 2
SEL_W, 2, width of the select index; must equal clog2(WIDTH)

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  reset, asynchronous and active-low
in_data  input  WIDTH  parallel word to be serialized
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a word this cycle
sel  output  SEL_W  current select index; drives an external mux select
ser_out  output  1  serial data bit, equal to stored_word[sel]
ser_valid  output  1  ser_out is valid
ser_ready  input  1  downstream accepts ser_out this cycle
ser_last  output  1  ser_out is bit WIDTH-1 of the current word
busy  output  1  a word is held and not fully emitted

Behaviour:
- State machine: IDLE, SHIFT, DRAIN. Word register (WIDTH bits) and bit counter (SEL_W bits) are both internal.
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - state=IDLE, word=0, counter=0
  - in_ready=0, ser_valid=0, ser_last=0, ser_out=0, sel=0, busy=0
  - Any in-flight word is discarded.
- First clock edge after rst_n rises: in_ready becomes 1. in_ready is a registered output and is 1 only in IDLE.
- IDLE:
  - in_valid && in_ready at an edge → capture in_data, counter=0, state=SHIFT, in_ready=0.
  - Otherwise remain in IDLE.
- SHIFT:
  - ser_valid=1; ser_out=word[counter]; sel=counter; ser_last=(counter==WIDTH-1); busy=1.
  - First bit is valid in the cycle immediately after the accepting edge, so load-to-first-bit latency is 1 cycle.
  - ser_valid && ser_ready at an edge with counter<WIDTH-1 → counter+1.
  - ser_valid && ser_ready at an edge with counter==WIDTH-1 → state=DRAIN.
  - ser_ready=0 → counter, ser_out, sel and ser_last hold stable. ser_valid never drops once asserted until the bit is accepted.
- DRAIN: lasts one cycle.
  - ser_valid=0, busy=0, counter=0, sel=0.
  - in_ready=1 at the next edge, state=IDLE.
  - Minimum spacing between word acceptances is WIDTH+2 cycles with ser_ready held high.
- Bit order: LSB first. Index 0 is emitted first, matching the select sequence 0,1,…,WIDTH-1.
- Counter never wraps inside a word; wrap from WIDTH-1 to 0 happens only via DRAIN.
- sel is 0 whenever ser_valid=0.
- in_valid while in_ready=0: ignored, no capture, no error. The upstream stage must hold its word until in_ready.
- in_data is sampled only on the accepting edge. Later changes to in_data do not affect the word in flight.
- ser_ready asserted while ser_valid=0: no effect.
- Reset asserted mid-SHIFT: outputs go to reset values without waiting for a clock edge. No partial bits are emitted after reset is released.
- No combinational path from in_valid or ser_ready to any output. All outputs are registered or decoded from registered state.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles, release → in_ready=0 during reset, in_ready=1 one edge after release; ser_valid=0, sel=0.
- Basic serialization: in_data=4'b1010, in_valid pulse, ser_ready=1 → ser_out sequence 0,1,0,1 on 4 consecutive cycles with sel=0,1,2,3; ser_last=1 only with sel=3; in_ready=1 two edges after the last bit.
- Backpressure: in_data=4'b0110, ser_ready=0 for 5 cycles after the first bit → ser_out=0, sel=0 and ser_valid=1 held stable; after release, remaining bits 1,1,0 emitted.
- Ignored input while busy: load 4'b1100, then in_valid=1 with in_data=4'b0011 during SHIFT → output stream stays 0,0,1,1; 4'b0011 is accepted only after in_ready=1 and produces 1,1,0,0.
- Async reset mid-word: load 4'b1111, assert rst_n=0 between edges after 2 bits → ser_valid=0, sel=0, busy=0 immediately; after release, no residual bits and in_ready=1 one edge later.
- Back-to-back throughput: 3 words 4'b0001, 4'b1000, 4'b0101 with in_valid held high and ser_ready=1 → streams 1000, 0001, 1010 LSB-first; consecutive word acceptances exactly 6 cycles apart.
